// File: rtl/muldiv_pkg.sv
// Shared definitions for the multi-cycle multiply/divide sequencer:
// ALU operation codes, FSM state encoding and operation select.
package muldiv_pkg;

  localparam int WIDTH = 32;
  localparam int CNT_W = 6;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  typedef enum logic {
    MD_MUL = 1'b0,
    MD_DIV = 1'b1
  } md_op_e;

endpackage

// File: rtl/muldiv_sequencer.sv
// Unsigned WIDTHxWIDTH multiply (shift-add) / divide (restoring) into HI/LO,
// one step per cycle through the borrowed shared ALU.
//
// state | meaning
// IDLE  | waiting for start; hi/lo/div_zero hold the last result
// RUN   | one multiply or divide step per cycle, ALU owned
// DONE  | one-cycle done pulse, result valid
module muldiv_sequencer
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] opa,
  input  logic [WIDTH-1:0] opb,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             alu_own,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [2:0]       alu_op,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_c_out
);

  state_e             state_q, state_d;
  md_op_e             op_q, op_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic [WIDTH-1:0]   opnd_q, opnd_d;
  logic               dz_q, dz_d;
  logic [WIDTH-1:0]   rem_shift;

  // Multiplicand (mul) or divisor (div) share one operand register.
  assign rem_shift = {hi_q[WIDTH-2:0], lo_q[WIDTH-1]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      op_q    <= MD_MUL;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      opnd_q  <= '0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      opnd_q  <= opnd_d;
      dz_q    <= dz_d;
    end
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    opnd_d  = opnd_q;
    dz_d    = dz_q;
    alu_own = 1'b0;
    alu_a   = '0;
    alu_b   = '0;
    alu_op  = ALU_ADD;

    case (state_q)
      IDLE: begin
        if (start) begin
          op_d  = md_op_e'(op);
          dz_d  = 1'b0;
          cnt_d = '0;
          if (md_op_e'(op) == MD_MUL) begin
            opnd_d  = opa;
            hi_d    = '0;
            lo_d    = opb;
            state_d = RUN;
          end else if (opb != '0) begin
            opnd_d  = opb;
            hi_d    = '0;
            lo_d    = opa;
            state_d = RUN;
          end else begin
            opnd_d  = opb;
            hi_d    = opa;
            lo_d    = '1;
            dz_d    = 1'b1;
            state_d = DONE;
          end
        end
      end

      RUN: begin
        alu_own = 1'b1;
        cnt_d   = cnt_q + CNT_W'(1);
        if (op_q == MD_MUL) begin
          alu_a  = hi_q;
          alu_b  = opnd_q;
          alu_op = ALU_ADD;
          if (lo_q[0]) begin
            hi_d = {alu_c_out, alu_result[WIDTH-1:1]};
            lo_d = {alu_result[0], lo_q[WIDTH-1:1]};
          end else begin
            hi_d = {1'b0, hi_q[WIDTH-1:1]};
            lo_d = {hi_q[0], lo_q[WIDTH-1:1]};
          end
        end else begin
          alu_a  = rem_shift;
          alu_b  = opnd_q;
          alu_op = ALU_SUB;
          // A set hi MSB means the shifted remainder exceeds WIDTH bits, so it always covers the divisor.
          if (hi_q[WIDTH-1] || alu_c_out) begin
            hi_d = alu_result;
            lo_d = {lo_q[WIDTH-2:0], 1'b1};
          end else begin
            hi_d = rem_shift;
            lo_d = {lo_q[WIDTH-2:0], 1'b0};
          end
        end
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          state_d = DONE;
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign busy     = (state_q != IDLE);
  assign done     = (state_q == DONE);
  assign div_zero = dz_q;
  assign hi       = hi_q;
  assign lo       = lo_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Scoreboard bench for muldiv_sequencer with a behavioural shared ALU behind the ownership mux.
module tb_muldiv_sequencer;
  import muldiv_pkg::*;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         op = 1'b0;
  logic [W-1:0] opa = '0;
  logic [W-1:0] opb = '0;
  logic         busy, done, div_zero, alu_own, alu_c_out;
  logic [W-1:0] hi, lo, alu_a, alu_b, alu_result;
  logic [2:0]   alu_op;

  logic [W-1:0] pipe_a, pipe_b, mux_a, mux_b;
  logic [2:0]   pipe_op, mux_op;

  muldiv_sequencer #(.WIDTH(W), .CNT_W(6)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .opa(opa), .opb(opb),
    .busy(busy), .done(done), .div_zero(div_zero), .hi(hi), .lo(lo),
    .alu_own(alu_own), .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .alu_result(alu_result), .alu_c_out(alu_c_out)
  );

  always #5 clk = ~clk;

  // Pipeline side of the mux carries junk so a missing alu_own corrupts results.
  assign pipe_a  = 32'hDEAD_BEEF;
  assign pipe_b  = 32'h0F0F_1234;
  assign pipe_op = ALU_OR;
  assign mux_a   = alu_own ? alu_a  : pipe_a;
  assign mux_b   = alu_own ? alu_b  : pipe_b;
  assign mux_op  = alu_own ? alu_op : pipe_op;

  always_comb begin
    {alu_c_out, alu_result} = '0;
    case (mux_op)
      ALU_AND: alu_result = mux_a & mux_b;
      ALU_OR:  alu_result = mux_a | mux_b;
      ALU_ADD: {alu_c_out, alu_result} = {1'b0, mux_a} + {1'b0, mux_b};
      ALU_SUB: {alu_c_out, alu_result} = {1'b0, mux_a} + {1'b0, ~mux_b} + 33'd1;
      ALU_SLT: alu_result = {31'd0, (mux_a < mux_b)};
      default: {alu_c_out, alu_result} = '0;
    endcase
  end

  typedef struct {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         dz;
    int           acc;
    int           lat;
    int           own;
    int           id;
  } exp_t;

  exp_t sb[$];
  int n_tests = 0;
  int n_fail = 0;
  int cyc = 0;
  int own_cnt = 0;
  int idle_bad = 0;
  int op_id = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  always @(posedge clk) cyc++;

  // Monitor: pops one expected result per done pulse.
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      own_cnt = 0;
    end else begin
      if (alu_own) own_cnt++;
      else if (alu_a !== '0 || alu_b !== '0 || alu_op !== ALU_ADD) idle_bad++;
      if (done) begin
        if (sb.size() == 0) begin
          check("unexpected_done", 64'd1, 64'd0);
        end else begin
          e = sb.pop_front();
          check($sformatf("op%0d_hi", e.id), hi, e.hi);
          check($sformatf("op%0d_lo", e.id), lo, e.lo);
          check($sformatf("op%0d_div_zero", e.id), div_zero, e.dz);
          check($sformatf("op%0d_latency", e.id), cyc - e.acc, e.lat);
          check($sformatf("op%0d_alu_own_cycles", e.id), own_cnt, e.own);
        end
        own_cnt = 0;
      end
    end
  end

  task automatic wait_idle();
    int t = 0;
    while (busy && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (busy) check("idle_timeout", 64'd1, 64'd0);
  endtask

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic issue(input logic o, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W-1:0] ehi, input logic [W-1:0] elo, input logic edz,
                       input bit push);
    exp_t e;
    wait_idle();
    op_id++;
    if (push) begin
      e.hi  = ehi;
      e.lo  = elo;
      e.dz  = edz;
      e.acc = cyc + 1;
      e.lat = (o && b == '0) ? 0 : W;
      e.own = (o && b == '0) ? 0 : W;
      e.id  = op_id;
      sb.push_back(e);
    end
    start = 1'b1;
    op    = o;
    opa   = a;
    opb   = b;
    @(negedge clk);
    start = 1'b0;
  endtask

  initial begin
    int t;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_div_zero", div_zero, 0);
    check("rst_hi", hi, 0);
    check("rst_lo", lo, 0);
    check("rst_alu_own", alu_own, 0);
    check("rst_alu_op", alu_op, ALU_ADD);
    rst_n = 1'b1;
    @(negedge clk);

    issue(1'b0, 32'd6, 32'd7, 32'd0, 32'd42, 1'b0, 1);
    issue(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0, 1);
    issue(1'b1, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0, 1);
    issue(1'b1, 32'h8000_0000, 32'd3, 32'd2, 32'h2AAA_AAAA, 1'b0, 1);
    issue(1'b1, 32'h1234_5678, 32'd0, 32'h1234_5678, 32'hFFFF_FFFF, 1'b1, 1);
    issue(1'b1, 32'd5, 32'd9, 32'd5, 32'd0, 1'b0, 1);
    issue(1'b0, 32'h1234_5678, 32'h10, 32'h1, 32'h2345_6780, 1'b0, 1);
    issue(1'b1, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'hFFFF_FFFF, 1'b0, 1);

    // Starts during RUN and DONE must be dropped.
    issue(1'b0, 32'h0001_0000, 32'h0003_0000, 32'h3, 32'h0, 1'b0, 1);
    repeat (4) @(negedge clk);
    start = 1'b1; op = 1'b1; opa = 32'h5555_5555; opb = 32'd0;
    @(negedge clk);
    start = 1'b0;
    repeat (26) @(negedge clk);
    start = 1'b1; op = 1'b1; opa = 32'h7777_7777; opb = 32'd0;
    repeat (2) @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    check("ignored_start_busy", busy, 0);
    check("hold_hi", hi, 32'h3);
    check("hold_lo", lo, 32'h0);
    check("hold_div_zero", div_zero, 0);

    // Reset in the middle of a multiply.
    issue(1'b0, 32'h1234, 32'h5678, 32'h0, 32'h0, 1'b0, 0);
    repeat (9) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort_busy", busy, 0);
    check("abort_hi", hi, 0);
    check("abort_lo", lo, 0);
    check("abort_done", done, 0);
    check("abort_alu_own", alu_own, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    issue(1'b1, 32'd9, 32'd2, 32'd1, 32'd4, 1'b0, 1);

    t = 0;
    while (sb.size() != 0 && t < 200) begin
      @(negedge clk);
      t++;
    end
    check("pending_results", sb.size(), 0);
    repeat (3) @(negedge clk);
    check("alu_idle_outputs", idle_bad, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
